ble_packet_serializer: RTL and testbench
========================================

BLE_PACKET_SERIALIZER -- requirements
Module: ble_packet_serializer

Interface
REQ-001 Parameter SAMPLES_PER_SYM, default 4: clk cycles per symbol (4 MHz clk, 1 Msym/s).
REQ-002 Parameter ACCESS_ADDR, default 32'h8E89BED6: access address, sent LSB first.
REQ-003 Parameter CRC_INIT, default 24'h555555: CRC-24 preset.
REQ-004 Port clk  in  1  sole clock; all logic on posedge clk.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port start  in  1  begin packet; sampled only in IDLE.
REQ-007 Port pdu_len  in  8  PDU byte count (0-255); latched on accepted start.
REQ-008 Port chan_idx  in  6  whitening channel index (0-39); latched on accepted start.
REQ-009 Port whiten_en  in  1  1 = whiten PDU+CRC; latched on accepted start.
REQ-010 Port byte_data  in  8  PDU byte, sent LSB first.
REQ-011 Port byte_valid  in  1  byte_data valid.
REQ-012 Port byte_ready  out  1  byte transfers when byte_valid and byte_ready are both 1 on a clk edge.
REQ-013 Port symVal  out  1  bit to FSK modulator symVal input, held SAMPLES_PER_SYM cycles per symbol.
REQ-014 Port busy  out  1  high in any state other than IDLE.
REQ-015 Port done  out  1  one-cycle pulse, packet complete.
REQ-016 Port underrun  out  1  one-cycle pulse, packet aborted because no byte was available.

Function
REQ-017 States: IDLE, PREAMBLE (8 sym), ACCADDR (32 sym), PDU (8*pdu_len sym), CRC (24 sym); PDU is skipped when pdu_len=0.
REQ-018 Start in IDLE -> PREAMBLE on the next edge; the first symbol appears on symVal in the cycle after start is sampled; start is ignored while busy.
REQ-019 A sample counter (0..SAMPLES_PER_SYM-1) advances the bit index on wrap; each symbol is held for exactly SAMPLES_PER_SYM cycles with no gaps between states.
REQ-020 Preamble is 8'h55 if ACCESS_ADDR[0]=1, else 8'hAA, sent LSB first.
REQ-021 One-byte holding buffer: byte_ready=1 iff busy, buffer empty and PDU bytes remain to be fetched; the first fetch is permitted from PREAMBLE onward.
REQ-022 The shift register reloads from the buffer at the symbol boundary that starts each PDU byte.
REQ-023 If the buffer is empty at a reload, the block pulses underrun, drives symVal=0 and returns to IDLE on the same edge; done is not pulsed.
REQ-024 CRC-24 is computed over unwhitened PDU bits in transmit order, per bit d: fb=crc[23]^d; crc={crc[22:0],0} xor (fb ? 24'h00065B : 0).
REQ-025 The CRC register is preset to CRC_INIT on accepted start.
REQ-026 CRC is sent crc[23] first, 24 symbols.
REQ-027 Whitening LFSR preset on accepted start: lfsr[0]=1, lfsr[1]=chan_idx[5], lfsr[2]=chan_idx[4], ... lfsr[6]=chan_idx[0].
REQ-028 Per PDU/CRC bit: w=lfsr[6]; sent bit = bit ^ (whiten_en & w); next lfsr = {lfsr[5], lfsr[4], lfsr[3]^w, lfsr[2], lfsr[1], lfsr[0], w}.
REQ-029 Preamble and access address are never whitened and never enter the CRC.
REQ-030 After the last sample of the last CRC symbol: done pulses in the next cycle, the block enters IDLE, symVal=0, and a new start is accepted in that same cycle.
REQ-031 Total packet length is (40 + 8*pdu_len + 24) * SAMPLES_PER_SYM cycles.
REQ-032 symVal=0 while IDLE.

Reset
REQ-033 On rst=1 at a clk edge, in any state: state=IDLE; symVal, busy, done, underrun and byte_ready = 0; counters cleared; buffer emptied; rst overrides start.
REQ-034 Reset mid-packet truncates output immediately; there is no partial done and no underrun pulse.

Verification
REQ-035 pdu_len=0, whiten_en=0, start at cycle T -> symVal = 0,1,0,1,0,1,0,1 (0xAA), then 0xD6,0xBE,0x89,0x8E LSB-first, then CRC_INIT 0x555555 MSB-first; done at T+257; busy high for 256 cycles.
REQ-036 pdu_len=2, bytes 0x00,0xFF always valid, whiten_en=0 -> PDU symbols 0x00 then 0xFF LSB-first, CRC bit-exact to the golden model, done at T+1+(40+16+24)*4.
REQ-037 Same packet with whiten_en=1, chan_idx=37 -> PDU+CRC equal the REQ-036 bits XOR the LFSR sequence from preset 7'b1010011 (lfsr[6:0]); preamble and access address unchanged.
REQ-038 pdu_len=3, byte_valid dropped after the first byte -> underrun pulses at the reload boundary of byte 2 (cycle T+1+(40+8)*4), symVal=0, busy=0, no done.
REQ-039 rst asserted during ACCADDR -> next cycle all outputs 0; subsequent start with pdu_len=0 reproduces the REQ-035 sequence exactly.
REQ-040 start held high through a packet -> second packet begins the cycle done pulses with no idle symbol; start pulses while busy are ignored.

Source files
------------

// File: rtl/ble_packet_serializer.sv
// BLE packet serializer: preamble, access address, optional PDU and CRC-24,
// emitted one bit per symbol on symVal, each symbol held SAMPLES_PER_SYM
// clocks. PDU and CRC bits are optionally whitened with the channel LFSR.
module ble_packet_serializer #(
  parameter int          SAMPLES_PER_SYM = 4,
  parameter logic [31:0] ACCESS_ADDR     = 32'h8E89BED6,
  parameter logic [23:0] CRC_INIT        = 24'h555555
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pdu_len,
  input  logic [5:0] chan_idx,
  input  logic       whiten_en,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       symVal,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int          SW            = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLES_PER_SYM - 1);
  // Preamble alternates so that its last bit differs from the first access address bit.
  localparam logic [7:0]  PREAMBLE_BYTE = ACCESS_ADDR[0] ? 8'h55 : 8'hAA;
  localparam logic [23:0] CRC_POLY      = 24'h00065B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_ACCADDR,
    S_PDU,
    S_CRC
  } state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   sample_cnt_reg;
  logic [4:0]      bit_cnt_reg;
  logic [7:0]      len_reg;
  logic [7:0]      tx_left_reg;     // PDU bytes still to be loaded into the shifter
  logic [7:0]      fetch_left_reg;  // PDU bytes still to be taken from the byte port
  logic [7:0]      buf_reg;
  logic            buf_full_reg;
  logic [7:0]      shift_reg;
  logic [23:0]     crc_reg;
  logic [6:0]      lfsr_reg;
  logic            whiten_reg;
  logic            done_reg;
  logic            underrun_reg;

  logic            sym_end;
  logic            accept;
  logic            reload;
  logic            done_next;
  logic            underrun_next;
  logic            sym_bit;
  logic            lfsr_w;
  logic [6:0]      lfsr_preset;

  // Whitening preset: bit 0 forced to one, bits 1..6 take the channel index MSB-first.
  assign lfsr_preset[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_lfsr_preset
      assign lfsr_preset[gi+1] = chan_idx[5-gi];
    end
  endgenerate

  assign sym_end    = (sample_cnt_reg == SAMPLE_LAST);
  assign lfsr_w     = lfsr_reg[6];
  assign busy       = (state_reg != S_IDLE);
  assign byte_ready = busy && !buf_full_reg && (fetch_left_reg != 8'd0);
  assign done       = done_reg;
  assign underrun   = underrun_reg;
  assign symVal     = sym_bit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and per-edge control strobes.
  always_comb begin
    state_next    = state_reg;
    accept        = 1'b0;
    reload        = 1'b0;
    done_next     = 1'b0;
    underrun_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (sym_end && bit_cnt_reg == 5'd7) state_next = S_ACCADDR;
      end
      S_ACCADDR: begin
        if (sym_end && bit_cnt_reg == 5'd31) begin
          if (len_reg == 8'd0) begin
            state_next = S_CRC;
          end else if (buf_full_reg) begin
            reload     = 1'b1;
            state_next = S_PDU;
          end else begin
            underrun_next = 1'b1;
            state_next    = S_IDLE;
          end
        end
      end
      S_PDU: begin
        if (sym_end && bit_cnt_reg == 5'd7) begin
          if (tx_left_reg == 8'd0) begin
            state_next = S_CRC;
          end else if (buf_full_reg) begin
            reload = 1'b1;
          end else begin
            underrun_next = 1'b1;
            state_next    = S_IDLE;
          end
        end
      end
      S_CRC: begin
        if (sym_end && bit_cnt_reg == 5'd23) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Bit currently on air; zero whenever idle.
  always_comb begin
    sym_bit = 1'b0;
    case (state_reg)
      S_PREAMBLE: sym_bit = PREAMBLE_BYTE[bit_cnt_reg[2:0]];
      S_ACCADDR:  sym_bit = ACCESS_ADDR[bit_cnt_reg];
      S_PDU:      sym_bit = shift_reg[0] ^ (whiten_reg & lfsr_w);
      S_CRC:      sym_bit = crc_reg[23] ^ (whiten_reg & lfsr_w);
      default:    sym_bit = 1'b0;
    endcase
  end

  // Datapath: counters, byte buffer, shifter, CRC and whitening LFSR.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt_reg <= '0;
      bit_cnt_reg    <= '0;
      len_reg        <= '0;
      tx_left_reg    <= '0;
      fetch_left_reg <= '0;
      buf_reg        <= '0;
      buf_full_reg   <= 1'b0;
      shift_reg      <= '0;
      crc_reg        <= '0;
      lfsr_reg       <= '0;
      whiten_reg     <= 1'b0;
      done_reg       <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      done_reg     <= done_next;
      underrun_reg <= underrun_next;

      if (byte_ready && byte_valid) begin
        buf_reg        <= byte_data;
        buf_full_reg   <= 1'b1;
        fetch_left_reg <= fetch_left_reg - 8'd1;
      end

      if (accept) begin
        sample_cnt_reg <= '0;
        bit_cnt_reg    <= '0;
        len_reg        <= pdu_len;
        fetch_left_reg <= pdu_len;
        buf_full_reg   <= 1'b0;
        crc_reg        <= CRC_INIT;
        lfsr_reg       <= lfsr_preset;
        whiten_reg     <= whiten_en;
      end else if (state_reg != S_IDLE) begin
        sample_cnt_reg <= sym_end ? '0 : sample_cnt_reg + SW'(1);
        if (sym_end) begin
          if (state_next != state_reg || reload) bit_cnt_reg <= '0;
          else                                   bit_cnt_reg <= bit_cnt_reg + 5'd1;
          if (state_reg == S_PDU) begin
            // CRC runs over the unwhitened bit just sent.
            crc_reg   <= {crc_reg[22:0], 1'b0} ^ ((crc_reg[23] ^ shift_reg[0]) ? CRC_POLY : 24'h0);
            shift_reg <= {1'b0, shift_reg[7:1]};
          end
          if (state_reg == S_CRC) crc_reg <= {crc_reg[22:0], 1'b0};
          if (state_reg == S_PDU || state_reg == S_CRC)
            lfsr_reg <= {lfsr_reg[5], lfsr_reg[4], lfsr_reg[3] ^ lfsr_w,
                         lfsr_reg[2], lfsr_reg[1], lfsr_reg[0], lfsr_w};
        end
        if (reload) begin
          shift_reg    <= buf_reg;
          buf_full_reg <= 1'b0;
          tx_left_reg  <= (state_reg == S_ACCADDR) ? len_reg - 8'd1 : tx_left_reg - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ble_packet_serializer.sv
// Bench for ble_packet_serializer: stimulus pushes expected per-cycle records
// computed from a frame-level reference model; a monitor pops and compares.
module tb_ble_packet_serializer;

  localparam int          SPS   = 4;
  localparam logic [31:0] AA    = 32'h8E89BED6;
  localparam logic [23:0] CINIT = 24'h555555;

  localparam logic [1:0] K_SYM   = 2'd0;
  localparam logic [1:0] K_DONE  = 2'd1;
  localparam logic [1:0] K_UNDER = 2'd2;
  localparam logic [1:0] K_RST   = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic       sym;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pdu_len;
  logic [5:0] chan_idx;
  logic       whiten_en;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       symVal;
  logic       busy;
  logic       done;
  logic       underrun;

  rec_t       exp_q[$];
  logic [7:0] byte_q[$];
  logic [7:0] pkt_bytes[$];
  bit         rand_valid = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  ble_packet_serializer #(
    .SAMPLES_PER_SYM(SPS),
    .ACCESS_ADDR    (AA),
    .CRC_INIT       (CINIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pdu_len   (pdu_len),
    .chan_idx  (chan_idx),
    .whiten_en (whiten_en),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .symVal    (symVal),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp, input logic [4:0] mask);
    checks++;
    if (((act ^ exp) & mask) !== 5'b0) begin
      errors++;
      $display("FAIL %s at %0t: busy,done,underrun,symVal,byte_ready got=%b required=%b mask=%b",
               name, $time, act, exp, mask);
    end
  endtask

  // Reference model: build the whole on-air frame as a bit list, then expand to cycles.
  task automatic push_model(input int len, input logic [5:0] chan, input bit wen,
                            input int supplied, input int max_cyc);
    bit          frame[$];
    bit          payload[$];
    logic [7:0]  pre;
    logic [23:0] crc;
    logic [6:0]  wl;
    bit          w;
    bit          fb;
    int          nsym;
    rec_t        r;
    pre = AA[0] ? 8'h55 : 8'hAA;
    for (int i = 0; i < 8; i++)  frame.push_back(pre[i]);
    for (int i = 0; i < 32; i++) frame.push_back(AA[i]);
    for (int b = 0; b < len; b++)
      for (int i = 0; i < 8; i++) payload.push_back(pkt_bytes[b][i]);
    crc = CINIT;
    foreach (payload[k]) begin
      fb  = crc[23] ^ payload[k];
      crc = {crc[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h0);
    end
    for (int i = 23; i >= 0; i--) payload.push_back(crc[i]);
    wl = {chan[0], chan[1], chan[2], chan[3], chan[4], chan[5], 1'b1};
    foreach (payload[k]) begin
      w = wl[6];
      frame.push_back(payload[k] ^ (wen & w));
      wl = {wl[5], wl[4], wl[3] ^ w, wl[2], wl[1], wl[0], w};
    end
    nsym = (supplied < len) ? 40 + 8 * supplied : frame.size();
    for (int i = 0; i < nsym * SPS && i < max_cyc; i++) begin
      r.kind = K_SYM;
      r.sym  = frame[i / SPS];
      exp_q.push_back(r);
    end
    if (nsym * SPS <= max_cyc) begin
      r.kind = (supplied < len) ? K_UNDER : K_DONE;
      r.sym  = 1'b0;
      exp_q.push_back(r);
    end
  endtask

  task automatic fill_bytes(input int n);
    pkt_bytes.delete();
    for (int i = 0; i < n; i++) pkt_bytes.push_back(8'($urandom));
  endtask

  // Called just after a posedge with the DUT idle.
  task automatic send(input int len, input logic [5:0] chan, input bit wen,
                      input int supplied, input bit hold);
    $display("packet len=%0d chan=%0d whiten=%0d supplied=%0d", len, chan, wen, supplied);
    for (int i = 0; i < supplied; i++) byte_q.push_back(pkt_bytes[i]);
    pdu_len   = 8'(len);
    chan_idx  = chan;
    whiten_en = wen;
    start     = 1'b1;
    push_model(len, chan, wen, supplied, 1 << 30);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic drain(input bit check_bytes);
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain timeout: %0d expected records left, required 0", exp_q.size());
      exp_q.delete();
    end
    if (check_bytes) begin
      checks++;
      if (byte_q.size() != 0) begin
        errors++;
        $display("FAIL bytes_fetched: %0d bytes not taken, required 0", byte_q.size());
        byte_q.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  // Monitor: one record per cycle in which the DUT shows activity.
  initial begin
    rec_t       r;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      act = {busy, done, underrun, symVal, byte_ready};
      if (exp_q.size() > 0 && (busy === 1'b1 || done === 1'b1 || underrun === 1'b1 || exp_q[0].kind == K_RST)) begin
        r = exp_q.pop_front();
        case (r.kind)
          K_SYM:   check5("sym",      act, {3'b100, r.sym, 1'b0}, 5'b11110);
          K_DONE:  check5("done",     act, 5'b01000, 5'b11111);
          K_UNDER: check5("underrun", act, 5'b00100, 5'b11111);
          default: check5("reset",    act, 5'b00000, 5'b11111);
        endcase
      end else if (busy === 1'b1 || done === 1'b1 || underrun === 1'b1) begin
        check5("unexpected_activity", act, 5'b00000, 5'b11100);
      end
    end
  end

  // Byte source: offers the head of byte_q; handshake judged on the stable pre-edge values.
  initial begin
    bit hs;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    forever begin
      @(negedge clk);
      hs = (byte_valid === 1'b1 && byte_ready === 1'b1);
      @(posedge clk); #1;
      if (hs && byte_q.size() > 0) void'(byte_q.pop_front());
      if (byte_q.size() > 0) begin
        byte_valid = rand_valid ? 1'($urandom) : 1'b1;
        byte_data  = byte_q[0];
      end else begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end
    end
  end

  initial begin
    rec_t r;
    int   k;
    int   len;
    rst = 1'b1; start = 1'b0; pdu_len = 8'd0; chan_idx = 6'd0; whiten_en = 1'b0;
    repeat (3) @(posedge clk); #1;
    r.kind = K_RST; r.sym = 1'b0;
    exp_q.push_back(r);
    start = 1'b1;                // reset must win over start
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b0;
    drain(1'b0);

    // Empty PDU, no whitening.
    fill_bytes(0);
    send(0, 6'd5, 1'b0, 0, 1'b0);
    drain(1'b1);

    // Two bytes 0x00, 0xFF, plain then whitened on channel 37.
    pkt_bytes.delete(); pkt_bytes.push_back(8'h00); pkt_bytes.push_back(8'hFF);
    send(2, 6'd37, 1'b0, 2, 1'b0);
    drain(1'b1);
    send(2, 6'd37, 1'b1, 2, 1'b0);
    drain(1'b1);

    // Three-byte PDU with only one byte ever supplied.
    fill_bytes(3);
    send(3, 6'd12, 1'b0, 1, 1'b0);
    drain(1'b1);

    // Reset in the middle of the access address.
    fill_bytes(4);
    for (int i = 0; i < 4; i++) byte_q.push_back(pkt_bytes[i]);
    $display("packet len=4 chan=9 whiten=1 reset-in-accaddr");
    pdu_len = 8'd4; chan_idx = 6'd9; whiten_en = 1'b1; start = 1'b1;
    k = 8 * SPS + $urandom_range(0, 32 * SPS - 1);
    push_model(4, 6'd9, 1'b1, 4, k + 1);
    r.kind = K_RST; r.sym = 1'b0;
    exp_q.push_back(r);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (k) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    byte_q.delete();
    drain(1'b0);
    fill_bytes(0);
    send(0, 6'd5, 1'b0, 0, 1'b0);
    drain(1'b1);

    // Start held high: second packet follows the done cycle directly.
    fill_bytes(1);
    send(1, 6'd20, 1'b1, 1, 1'b1);
    fill_bytes(1);
    byte_q.push_back(pkt_bytes[0]);
    $display("packet len=1 chan=20 whiten=1 back-to-back");
    push_model(1, 6'd20, 1'b1, 1, 1 << 30);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk); #1;
    pdu_len = 8'd7; chan_idx = 6'd1; start = 1'b1;   // ignored while busy
    @(posedge clk); #1;
    start = 1'b0;
    drain(1'b1);

    // Randomized packets with gappy byte_valid.
    rand_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      len = $urandom_range(0, 12);
      fill_bytes(len);
      send(len, 6'($urandom_range(0, 39)), 1'($urandom), len, 1'b0);
      drain(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
